cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter sharing the single common data bus (CDB) between the result producers of the out-of-order core: three adders, two multipliers, and the load/store unit. Each producer hands over a tagged result with a one-cycle valid pulse. The arbiter holds results that lose arbitration in a per-source holding register and broadcasts exactly one result per cycle on a registered CDB. The broadcast feeds the reservation stations and the order manager. Each source gets a back-pressure ready so the reservation-station layer can delay issuing start to that unit.

## Interface
- N_SRC, 6: number of requesters; index 0..2 = ADD1..ADD3, 3..4 = MUL1..MUL2, 5 = LS.
- DATA_W, 32: result width.
- TAG_W, 4: tag width (reservation-station index of the producing entry).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all pending and outgoing results.
- src_valid  in  N_SRC  per-source result pulse; bit i qualifies src_tag/src_data slice i.
- src_tag  in  N_SRC*TAG_W  packed tags; slice i = bits [i*TAG_W +: TAG_W].
- src_data  in  N_SRC*DATA_W  packed results; slice i = bits [i*DATA_W +: DATA_W].
- src_ready  out  N_SRC  bit i high = source i may pulse src_valid this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast data.
- cdb_src  out  N_SRC  registered one-hot identifying the winning source.
- overflow  out  N_SRC  sticky error: source i pulsed valid while src_ready[i] was low.

## Operation
- State per source i:
  - pend[i], a 1-bit flag.
  - hold_tag[i] and hold_data[i], the holding register.
- Global state:
  - rr_ptr, the index of the last granted source (width clog2(N_SRC)).
- src_ready[i] = ~pend[i], taken purely from a register with no combinational path from src_valid. A source whose entry is pending sees ready low even in the cycle that entry is granted.
- Candidate: cand[i] = pend[i] | (src_valid[i] & src_ready[i]).
- Candidate contents: a pending entry always comes from the holding register. Otherwise the candidate is the live input slice.
- Arbitration:
  - Search order is rr_ptr+1, rr_ptr+2, … wrapping mod N_SRC. The first cand[i] found wins.
  - On a grant, rr_ptr <= winner. With no candidate, rr_ptr holds.
- Each edge with at least one candidate:
  - cdb_valid <= 1, and cdb_tag/cdb_data/cdb_src <= the winner's contents.
  - A winner that was pending clears pend.
  - A losing live input is captured: pend[i] <= 1 and the holding register loads that slice.
  - Losing pending entries keep their state.
- Each edge with no candidate: cdb_valid <= 0, and cdb_tag/cdb_data/cdb_src <= 0.
- overflow[i] is set when src_valid[i] & ~src_ready[i]. That input is dropped and the existing pending entry is untouched. overflow clears only on reset.
- flush, which has priority over all other updates:
  - pend <= 0 and cdb_valid <= 0; cdb_tag/cdb_data/cdb_src <= 0.
  - src_valid in the flush cycle is ignored and not captured.
  - rr_ptr and overflow are unchanged.

## Timing
- Reset (asynchronous assert) gives:
  - pend = 0, hold_* = 0, rr_ptr = N_SRC-1 (source 0 has first priority).
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0.
  - overflow = 0, src_ready = all ones.
- Latency through an idle arbiter: src_valid sampled at edge E, broadcast valid in the cycle after E (1 cycle).
- Throughput: one broadcast per cycle. Worst-case wait for a pending entry is N_SRC-1 grants.
- Simultaneous valid from all six sources on one edge:
  - the winner goes out at once and the other five become pending;
  - they drain over the next five cycles in round-robin order;
  - each source's ready returns high the cycle after its entry is broadcast.
- Reset mid-operation discards everything with no partial broadcast. cdb_valid is low from reset assertion onward.

## Test plan
- Idle after reset, src_valid=6'b000001, tag 4'h3, data 32'h0000_00AA → next cycle cdb_valid=1, cdb_tag=3, cdb_data=AA, cdb_src=000001; the cycle after, cdb_valid=0.
- All six valid on one edge, data = 100+i → six consecutive broadcasts of 100, 101, …, 105; src_ready[5] is low for 5 cycles; rr_ptr ends at 5.
- Continuous valid pulses from sources 1 and 4 whenever ready, each broadcast data = (source<<8)|count → broadcasts alternate between 1 and 4, neither starves, and no overflow.
- Source 2 pulses while its entry is pending (data DEAD after pending BEEF) → overflow[2]=1, BEEF is broadcast, DEAD is never broadcast.
- Three entries pending, flush asserted while source 0 pulses → next cycle cdb_valid=0, src_ready all ones, and nothing from before the flush is ever broadcast.
- Async reset asserted mid-drain, between clock edges → outputs are zero immediately; after release, a fresh pulse from source 5 broadcasts 1 cycle later.

Source files
------------

// File: rtl/cdb_if.sv
// Producer-to-CDB bundle: per-source tagged results in, one registered broadcast out.
// master = producer/flush side, slave = the arbiter.
interface cdb_if #(
  parameter int N_SRC  = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic                    flush;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [N_SRC-1:0]        cdb_src;
  logic [N_SRC-1:0]        overflow;

  modport master (
    output flush, src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow
  );

  modport slave (
    input  flush, src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one registered broadcast per cycle, 1-cycle latency when idle.
// Losers park in a per-source holding register; src_ready drops while that register is occupied.
module cdb_arbiter #(
  parameter int N_SRC  = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  cdb_if.slave   bus
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  pend;
  logic [TAG_W-1:0]  hold_tag  [N_SRC];
  logic [DATA_W-1:0] hold_data [N_SRC];
  logic [PTR_W-1:0]  rr_ptr;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [N_SRC-1:0]  cdb_src_q;
  logic [N_SRC-1:0]  overflow_q;

  logic [N_SRC-1:0]  live;
  logic [N_SRC-1:0]  cand;
  logic              found;
  logic [PTR_W-1:0]  win;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Ready comes straight from pend so no src_valid-to-src_ready path exists.
  assign live = bus.src_valid & ~pend;
  assign cand = pend | live;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!found && cand[(int'(rr_ptr) + k) % N_SRC]) begin
        found = 1'b1;
        win   = PTR_W'((int'(rr_ptr) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    win_tag  = bus.src_tag[int'(win)*TAG_W +: TAG_W];
    win_data = bus.src_data[int'(win)*DATA_W +: DATA_W];
    if (pend[win]) begin
      win_tag  = hold_tag[win];
      win_data = hold_data[win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      rr_ptr      <= PTR_W'(N_SRC - 1);
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      overflow_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (bus.flush) begin
      pend        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      // A pulse into an occupied slot is dropped; the parked entry is kept.
      overflow_q <= overflow_q | (bus.src_valid & pend);
      if (found) begin
        rr_ptr      <= win;
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= win_tag;
        cdb_data_q  <= win_data;
        cdb_src_q   <= {{(N_SRC-1){1'b0}}, 1'b1} << win;
        for (int i = 0; i < N_SRC; i++) begin
          if (i == int'(win)) begin
            pend[i] <= 1'b0;
          end else if (live[i]) begin
            pend[i]      <= 1'b1;
            hold_tag[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
            hold_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
          end
        end
      end else begin
        cdb_valid_q <= 1'b0;
        cdb_tag_q   <= '0;
        cdb_data_q  <= '0;
        cdb_src_q   <= '0;
      end
    end
  end

  assign bus.src_ready = ~pend;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.overflow  = overflow_q;
endmodule
